fb_host_bus: RTL
================

Name: fb_host_bus

Overview:
- Host-side bus initiator for the memory-mapped video frame buffer.
- Turns single-word read/write requests on a valid/ready interface into cs_n/oe_n/we_n strobe cycles on the frame buffer's 11-bit address / 8-bit bidirectional data bus.
- Sits between a CPU or test-pattern generator and the frame buffer.
- Owns bus timing, tri-state control and read-data capture.

Parameters:
ADDR_W, 11, address width (2 KB character store)
DATA_W, 8, data bus width
SETUP_CYC, 1, cycles cs_n is low before the strobe (>=1)
STROBE_CYC, 2, cycles oe_n/we_n is low (>=1)
HOLD_CYC, 1, cycles cs_n stays low after the strobe (>=0; 0 skips HOLD)

Ports:
clock  input  1  system clock, 50 MHz, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready at a rising edge
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: rsp_rdata valid
rsp_rdata  output  DATA_W  captured read data, held until next read
busy  output  1  transaction in progress (state != IDLE)
address  output  ADDR_W  frame buffer address
data  inout  DATA_W  frame buffer data bus
cs_n  output  1  chip select, active low
oe_n  output  1  output enable, active low
we_n  output  1  write enable, active low

Behaviour:
- Reset (async, reset_n=0):
  - cs_n=oe_n=we_n=1; data released (Z); address=0.
  - rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0; FSM to IDLE.
  - Takes effect immediately, including mid-transaction; any pending response is dropped.
- req_ready = 1 only in IDLE with reset_n high.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - IDLE: on accept, latch addr/wdata/write, go to SETUP.
  - SETUP: cs_n=0 for SETUP_CYC cycles; address valid from the first SETUP cycle.
  - STROBE: cs_n=0; we_n=0 (write) or oe_n=0 (read) for STROBE_CYC cycles.
  - HOLD: cs_n=0, strobes high, for HOLD_CYC cycles; if HOLD_CYC=0, go STROBE -> IDLE directly.
- A single down-counter, sized from the largest CYC parameter, times each state.
- All bus outputs are registered; no combinational path from req_* to the bus.
- Writes:
  - data driven with the latched wdata for the whole of SETUP, STROBE and HOLD.
  - data is Z in IDLE and during every read.
- Reads:
  - data is sampled at the rising edge that ends the last STROBE cycle.
  - At that edge rsp_rdata is loaded and rsp_valid pulses high for exactly the following cycle.
- Throughput and bus timing:
  - Transaction occupancy = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; defaults give 4.
  - Mandatory IDLE cycle between transactions: cs_n high >=1 cycle; back-to-back period 5 cycles at defaults.
  - address holds its last value in IDLE; it never changes while cs_n=0.
- req_* may change freely when req_ready=0; they are ignored until the next accept.
- Simultaneous req_valid and reset deassertion: no accept in the deassertion cycle (req_ready is registered and rises one cycle after reset release).

Optional Feature:
- Macro FB_HOST_BUS_VSYNC_WAIT_EN: tear-free writes.
- When defined:
  - Adds input vsync (1-bit, active low, same clock domain, from frame buffer), registered once internally as vsync_q.
  - Writes are only accepted while vsync_q=0: req_ready = IDLE & (!req_write | !vsync_q).
  - Reads are unaffected.
  - A write already in progress completes even if vsync rises mid-transaction.
- When undefined: no vsync port, no gating, behaviour exactly as above.

Test Plan:
- Reset: reset_n=0 for 5 cycles -> cs_n/oe_n/we_n=1, data=Z, req_ready=0; req_ready=1 on the first cycle after release edge.
- Write 0x123<=0xA5 (defaults) -> cs_n low 4 cycles starting the cycle after accept, we_n low cycles 2-3, data=0xA5 exactly those 4 cycles else Z; frame_buffer instance stores 0xA5.
- Read 0x123 after that write -> oe_n low 2 cycles, data never driven by host, rsp_valid single pulse with rsp_rdata=0xA5, busy low after 4 cycles.
- req_valid held high for 3 writes (0x000..0x002) -> three accepts 5 cycles apart, cs_n high exactly 1 cycle between them, address stable while cs_n low.
- reset_n pulsed low during the second STROBE cycle of a read -> strobes high and data Z in the same timestep, no rsp_valid; next write completes normally.
- FB_HOST_BUS_VSYNC_WAIT_EN defined, vsync=1 -> write held off (req_ready=0) and read accepted; vsync=0 -> write accepted 1 cycle after vsync_q falls.

Source files
------------

// File: rtl/fb_host_bus.sv
// fb_host_bus: turns valid/ready single-word requests into cs_n/oe_n/we_n frame-buffer bus cycles.
// Optional tear-free write gating on vsync is enabled by defining FB_HOST_BUS_VSYNC_WAIT_EN.
module fb_host_bus #(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
`ifdef FB_HOST_BUS_VSYNC_WAIT_EN
   input  logic              vsync,
`endif
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] address,
   inout  wire  [DATA_W-1:0] data,
   output logic              cs_n,
   output logic              oe_n,
   output logic              we_n
);

   localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_accept;
   logic              w_last;
   logic              w_write_nxt;
   logic              w_rd_capture;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic              r_cs_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic              r_drive;
   logic              r_busy;
   logic              r_idle_rdy;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rdata;

   // Write requests wait for the vsync-low window; reads are never gated.
`ifdef FB_HOST_BUS_VSYNC_WAIT_EN
   logic r_vsync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_vsync_q <= 1'b1;
      else          r_vsync_q <= vsync;
   end

   assign req_ready = r_idle_rdy & (~req_write | ~r_vsync_q);
`else
   assign req_ready = r_idle_rdy;
`endif

   // State and phase counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state: each bus phase lasts its configured cycle count, timed by one down-counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_last      = (r_cnt == '0);
      case (r_state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (w_last) begin
               w_state_nxt = ST_STROBE;
               w_cnt_nxt   = STROBE_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (w_last) begin
               if (HOLD_CYC == 0) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = HOLD_LD;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (w_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_write_nxt  = w_accept ? req_write : r_write;
   assign w_rd_capture = (r_state == ST_STROBE) && w_last && !r_write;

   // Bus outputs are registered from the next state so they line up with the phase they belong to.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write     <= 1'b0;
         r_cs_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_drive     <= 1'b0;
         r_busy      <= 1'b0;
         r_idle_rdy  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
         end
         r_cs_n      <= (w_state_nxt == ST_IDLE);
         r_we_n      <= !((w_state_nxt == ST_STROBE) && w_write_nxt);
         r_oe_n      <= !((w_state_nxt == ST_STROBE) && !w_write_nxt);
         r_drive     <= (w_state_nxt != ST_IDLE) && w_write_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_idle_rdy  <= (w_state_nxt == ST_IDLE);
         r_rsp_valid <= w_rd_capture;
         if (w_rd_capture) r_rdata <= data;
      end
   end

   assign data      = r_drive ? r_wdata : {DATA_W{1'bz}};
   assign address   = r_addr;
   assign cs_n      = r_cs_n;
   assign oe_n      = r_oe_n;
   assign we_n      = r_we_n;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;

endmodule
